reg_wb_ctrl: RTL and testbench

Writeback controller driving the write port of the 8×16 CPU register file. Merges single-cycle ALU results and multi-cycle memory/load results into one registered write per cycle. Buffers load results in a small FIFO and keeps a pending-write scoreboard. Flags read-after-write hazards for the two decode-stage read selects.

---
 rtl/reg_wb_pkg.sv | 14 +
 rtl/reg_wb_fifo.sv | 68 ++++++
 rtl/reg_wb_ctrl.sv | 137 +++++++++++++
 tb/tb_reg_wb_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_wb_pkg.sv
// Shared defaults and the load-result FIFO entry type for the writeback controller.
package reg_wb_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned NUM_REGS   = 8;
  localparam int unsigned SEL_W      = $clog2(NUM_REGS);
  localparam int unsigned FIFO_DEPTH = 2;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_wb_fifo.sv
// Small synchronous FIFO buffering load results ahead of the register-file write port.
module reg_wb_fifo import reg_wb_pkg::*; #(
  parameter int unsigned Width = $bits(wb_entry_t),
  parameter int unsigned Depth = FIFO_DEPTH,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [Width-1:0] pushData,
  input  logic            pop,
  output logic [Width-1:0] headData,
  output logic [CntW-1:0] count,
  output logic            empty
);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wrPtrQ, wrPtrD;
  logic [PtrW-1:0]  rdPtrQ, rdPtrD;
  logic [CntW-1:0]  countQ, countD;
  logic             doPush, doPop;
  logic             full;

  assign empty    = (countQ == '0);
  assign full     = (countQ == CntW'(Depth));
  assign doPush   = push && !full;
  assign doPop    = pop && !empty;
  assign count    = countQ;
  assign headData = mem[rdPtrQ];

  always_comb begin
    wrPtrD = wrPtrQ;
    rdPtrD = rdPtrQ;
    countD = countQ;
    if (doPush) begin
      wrPtrD = (wrPtrQ == PtrW'(Depth - 1)) ? '0 : wrPtrQ + PtrW'(1);
    end
    if (doPop) begin
      rdPtrD = (rdPtrQ == PtrW'(Depth - 1)) ? '0 : rdPtrQ + PtrW'(1);
    end
    unique case ({doPush, doPop})
      2'b10:   countD = countQ + CntW'(1);
      2'b01:   countD = countQ - CntW'(1);
      default: countD = countQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else begin
      wrPtrQ <= wrPtrD;
      rdPtrQ <= rdPtrD;
      countQ <= countD;
    end
  end

  // Storage needs no reset; the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtrQ] <= pushData;
    end
  end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Register-file writeback controller: ALU/load arbitration, pending-write scoreboard, RAW hazard.
// Define REG_WB_BYPASS_EN to forward the in-flight write to decode instead of stalling on it.
module reg_wb_ctrl #(
  parameter int unsigned DATA_W     = reg_wb_pkg::DATA_W,
  parameter int unsigned NUM_REGS   = reg_wb_pkg::NUM_REGS,
  parameter int unsigned FIFO_DEPTH = reg_wb_pkg::FIFO_DEPTH,
  localparam int unsigned SEL_W     = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid,
  input  logic [SEL_W-1:0]    alu_sel,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [SEL_W-1:0]    mem_sel,
  input  logic [DATA_W-1:0]   mem_data,
  input  logic                issue_en,
  input  logic [SEL_W-1:0]    issue_sel,
  input  logic [SEL_W-1:0]    ReadSelS,
  input  logic [SEL_W-1:0]    ReadSelT,
  output logic                hazard,
  output logic                WrRegEn,
  output logic [SEL_W-1:0]    WrSel,
  output logic [DATA_W-1:0]   DataIn,
  output logic [NUM_REGS-1:0] pending,
  output logic                FwdSEn,
  output logic                FwdTEn,
  output logic [DATA_W-1:0]   FwdS,
  output logic [DATA_W-1:0]   FwdT
);

  import reg_wb_pkg::*;

  localparam int unsigned EntryW = $bits(wb_entry_t);
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);

  wb_entry_t          pushEntry, headEntry;
  logic [EntryW-1:0]  headBits;
  logic [CntW-1:0]    fifoCount;
  logic               fifoEmpty;
  logic               fifoPush, fifoPop;

  logic               wrEnQ, wrEnD;
  logic [SEL_W-1:0]   wrSelQ, wrSelD;
  logic [DATA_W-1:0]  wrDataQ, wrDataD;
  logic [NUM_REGS-1:0] pendingQ, pendingD;
  logic               wrHitS, wrHitT;

  // Ready ignores a same-cycle pop so the push path never depends on arbitration.
  assign mem_ready = (fifoCount < CntW'(FIFO_DEPTH));
  assign fifoPush  = mem_valid && mem_ready;
  assign fifoPop   = !alu_valid && !fifoEmpty;

  assign pushEntry.sel  = mem_sel;
  assign pushEntry.data = mem_data;
  assign headEntry      = wb_entry_t'(headBits);

  reg_wb_fifo #(
    .Width (EntryW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifoPush),
    .pushData (pushEntry),
    .pop      (fifoPop),
    .headData (headBits),
    .count    (fifoCount),
    .empty    (fifoEmpty)
  );

  // ALU always wins; an idle cycle holds select and data so the write port stays quiet.
  always_comb begin
    wrEnD   = 1'b0;
    wrSelD  = wrSelQ;
    wrDataD = wrDataQ;
    if (alu_valid) begin
      wrEnD   = 1'b1;
      wrSelD  = alu_sel;
      wrDataD = alu_data;
    end else if (fifoPop) begin
      wrEnD   = 1'b1;
      wrSelD  = headEntry.sel;
      wrDataD = headEntry.data;
    end
  end

  // A new issue to the same register outranks retirement of the older load.
  always_comb begin
    pendingD = pendingQ;
    if (fifoPop) begin
      pendingD[headEntry.sel] = 1'b0;
    end
    if (issue_en) begin
      pendingD[issue_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrEnQ    <= 1'b0;
      wrSelQ   <= '0;
      wrDataQ  <= '0;
      pendingQ <= '0;
    end else begin
      wrEnQ    <= wrEnD;
      wrSelQ   <= wrSelD;
      wrDataQ  <= wrDataD;
      pendingQ <= pendingD;
    end
  end

  assign WrRegEn = wrEnQ;
  assign WrSel   = wrSelQ;
  assign DataIn  = wrDataQ;
  assign pending = pendingQ;

  assign wrHitS = wrEnQ && (wrSelQ == ReadSelS);
  assign wrHitT = wrEnQ && (wrSelQ == ReadSelT);

`ifdef REG_WB_BYPASS_EN
  assign hazard = pendingQ[ReadSelS] | pendingQ[ReadSelT];
  assign FwdSEn = wrHitS;
  assign FwdTEn = wrHitT;
  assign FwdS   = wrDataQ;
  assign FwdT   = wrDataQ;
`else
  // During the write cycle the register file still returns the old value.
  assign hazard = pendingQ[ReadSelS] | pendingQ[ReadSelT] | wrHitS | wrHitT;
  assign FwdSEn = 1'b0;
  assign FwdTEn = 1'b0;
  assign FwdS   = '0;
  assign FwdT   = '0;
`endif

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Randomised + directed bench for reg_wb_ctrl with a queue-based reference model and write scoreboard.
module tb_reg_wb_ctrl;

`ifdef REG_WB_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif
  localparam int Depth = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid = 1'b0;
  logic [2:0]  alu_sel = '0;
  logic [15:0] alu_data = '0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [2:0]  mem_sel = '0;
  logic [15:0] mem_data = '0;
  logic        issue_en = 1'b0;
  logic [2:0]  issue_sel = '0;
  logic [2:0]  ReadSelS = '0;
  logic [2:0]  ReadSelT = '0;
  logic        hazard;
  logic        WrRegEn;
  logic [2:0]  WrSel;
  logic [15:0] DataIn;
  logic [7:0]  pending;
  logic        FwdSEn, FwdTEn;
  logic [15:0] FwdS, FwdT;

  reg_wb_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_sel   (alu_sel),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_sel   (mem_sel),
    .mem_data  (mem_data),
    .issue_en  (issue_en),
    .issue_sel (issue_sel),
    .ReadSelS  (ReadSelS),
    .ReadSelT  (ReadSelT),
    .hazard    (hazard),
    .WrRegEn   (WrRegEn),
    .WrSel     (WrSel),
    .DataIn    (DataIn),
    .pending   (pending),
    .FwdSEn    (FwdSEn),
    .FwdTEn    (FwdTEn),
    .FwdS      (FwdS),
    .FwdT      (FwdT)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] sel; logic [15:0] data; } ent_t;
  typedef struct { int cyc; logic [2:0] sel; logic [15:0] data; } exp_t;

  int          nCmp = 0;
  int          nErr = 0;
  int          cycle = 0;
  ent_t        mq[$];
  exp_t        expQ[$];
  logic [7:0]  mPend;
  logic        mWrEn;
  logic [2:0]  mWrSel;
  logic [15:0] mWrData;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nCmp++;
    if (act !== req) begin
      nErr++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: every DUT write must match the oldest expected write, in the expected cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      while (expQ.size() > 0 && expQ[0].cyc < cycle) begin
        e = expQ.pop_front();
        nCmp++;
        nErr++;
        $display("FAIL wr_missing: actual none required r%0d=%h at cycle %0d", e.sel, e.data, e.cyc);
      end
      if (WrRegEn) begin
        if (expQ.size() == 0) begin
          nCmp++;
          nErr++;
          $display("FAIL wr_unexpected: actual r%0d=%h required none", WrSel, DataIn);
        end else begin
          e = expQ.pop_front();
          chk("wr_cycle", cycle, e.cyc);
          chk("wr_sel", {29'd0, WrSel}, {29'd0, e.sel});
          chk("wr_data", {16'd0, DataIn}, {16'd0, e.data});
        end
      end
    end
  end

  task automatic modelReset();
    mq.delete();
    expQ.delete();
    mPend = '0;
    mWrEn = 1'b0;
    mWrSel = '0;
    mWrData = '0;
  endtask

  task automatic chkOutputs(input logic [2:0] rs, input logic [2:0] rt);
    logic expHaz;
    expHaz = mPend[rs] | mPend[rt];
    if (!Bypass) expHaz = expHaz | (mWrEn && (mWrSel == rs || mWrSel == rt));
    chk("mem_ready", {31'd0, mem_ready}, {31'd0, mq.size() < Depth});
    chk("pending", {24'd0, pending}, {24'd0, mPend});
    chk("wr_en", {31'd0, WrRegEn}, {31'd0, mWrEn});
    if (!mWrEn) begin
      chk("hold_sel", {29'd0, WrSel}, {29'd0, mWrSel});
      chk("hold_data", {16'd0, DataIn}, {16'd0, mWrData});
    end
    chk("hazard", {31'd0, hazard}, {31'd0, expHaz});
    chk("fwd_s_en", {31'd0, FwdSEn}, {31'd0, Bypass && mWrEn && mWrSel == rs});
    chk("fwd_t_en", {31'd0, FwdTEn}, {31'd0, Bypass && mWrEn && mWrSel == rt});
    chk("fwd_s", {16'd0, FwdS}, {16'd0, Bypass ? mWrData : 16'h0});
    chk("fwd_t", {16'd0, FwdT}, {16'd0, Bypass ? mWrData : 16'h0});
  endtask

  // One clock: drive at the negedge, check combinational outputs, advance the model, clock.
  task automatic step(input logic av, input logic [2:0] as, input logic [15:0] ad,
                      input logic mv, input logic [2:0] ms, input logic [15:0] md,
                      input logic ie, input logic [2:0] is,
                      input logic [2:0] rs, input logic [2:0] rt);
    ent_t e;
    bit   acc;
    alu_valid = av; alu_sel = as; alu_data = ad;
    mem_valid = mv; mem_sel = ms; mem_data = md;
    issue_en = ie; issue_sel = is;
    ReadSelS = rs; ReadSelT = rt;
    #1;
    chkOutputs(rs, rt);
    acc = mv && (mq.size() < Depth);
    if (av) begin
      mWrEn = 1'b1; mWrSel = as; mWrData = ad;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      mPend[e.sel] = 1'b0;
      mWrEn = 1'b1; mWrSel = e.sel; mWrData = e.data;
    end else begin
      mWrEn = 1'b0;
    end
    if (ie) mPend[is] = 1'b1;
    if (acc) mq.push_back('{sel: ms, data: md});
    if (mWrEn) expQ.push_back('{cyc: cycle + 1, sel: mWrSel, data: mWrData});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic [2:0] rs, input logic [2:0] rt);
    step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, rs, rt);
  endtask

  task automatic chkReset();
    chk("rst_pending", {24'd0, pending}, 32'h0);
    chk("rst_mem_ready", {31'd0, mem_ready}, 32'h1);
    chk("rst_wr_en", {31'd0, WrRegEn}, 32'h0);
    chk("rst_wr_sel", {29'd0, WrSel}, 32'h0);
    chk("rst_data_in", {16'd0, DataIn}, 32'h0);
    chk("rst_hazard", {31'd0, hazard}, 32'h0);
    chk("rst_fwd_en", {30'd0, FwdSEn, FwdTEn}, 32'h0);
    chk("rst_fwd", {FwdS, FwdT}, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    modelReset();
    #3;
    chkReset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Single ALU write
    step(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd0);
    chk("alu_wr_en", {31'd0, WrRegEn}, 32'h1);
    chk("alu_wr_sel", {29'd0, WrSel}, 32'h3);
    chk("alu_wr_data", {16'd0, DataIn}, 32'hBEEF);
    idle(3'd0, 3'd0);
    chk("alu_wr_drop", {31'd0, WrRegEn}, 32'h0);

    // Load to r5 held off by three ALU cycles
    step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 3'd5, 3'd0);
    step(1'b1, 3'd1, 16'h1111, 1'b1, 3'd5, 16'h1234, 1'b0, 3'd0, 3'd5, 3'd0);
    chk("load_pend5", {31'd0, pending[5]}, 32'h1);
    chk("load_hazard", {31'd0, hazard}, 32'h1);
    step(1'b1, 3'd1, 16'h2222, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd5, 3'd0);
    step(1'b1, 3'd1, 16'h3333, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd5, 3'd0);
    idle(3'd5, 3'd0);
    chk("load_wr_sel", {29'd0, WrSel}, 32'h5);
    chk("load_wr_data", {16'd0, DataIn}, 32'h1234);
    chk("load_pend5_clr", {31'd0, pending[5]}, 32'h0);
    idle(3'd0, 3'd0);

    // FIFO full: third load refused, then two writes in push order
    step(1'b1, 3'd0, 16'h0AAA, 1'b1, 3'd1, 16'h00A1, 1'b0, 3'd0, 3'd0, 3'd0);
    step(1'b1, 3'd0, 16'h0BBB, 1'b1, 3'd2, 16'h00A2, 1'b0, 3'd0, 3'd0, 3'd0);
    chk("full_ready", {31'd0, mem_ready}, 32'h0);
    step(1'b1, 3'd0, 16'h0CCC, 1'b1, 3'd7, 16'h00A3, 1'b0, 3'd0, 3'd0, 3'd0);
    idle(3'd0, 3'd0);
    chk("full_wr1", {13'd0, WrSel, DataIn}, {13'd0, 3'd1, 16'h00A1});
    idle(3'd0, 3'd0);
    chk("full_wr2", {13'd0, WrRegEn, WrSel, DataIn}, {13'd0, 1'b1, 3'd2, 16'h00A2});
    idle(3'd0, 3'd0);
    chk("full_done", {31'd0, WrRegEn}, 32'h0);

    // Re-issue to r2 in the same cycle its older load retires
    step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 3'd0, 3'd0);
    step(1'b1, 3'd0, 16'h4444, 1'b1, 3'd2, 16'h0202, 1'b0, 3'd0, 3'd0, 3'd0);
    step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 3'd0, 3'd0);
    chk("setwins_pend2", {31'd0, pending[2]}, 32'h1);
    chk("setwins_wr", {29'd0, WrSel}, 32'h2);

    // Write-cycle read of r4
    step(1'b1, 3'd4, 16'h00FF, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd0);
    ReadSelS = 3'd0;
    ReadSelT = 3'd4;
    #1;
    if (Bypass) begin
      chk("byp_fwd_t_en", {31'd0, FwdTEn}, 32'h1);
      chk("byp_fwd_t", {16'd0, FwdT}, 32'h00FF);
      chk("byp_hazard", {31'd0, hazard}, 32'h0);
    end else begin
      chk("nobyp_hazard", {31'd0, hazard}, 32'h1);
    end
    idle(3'd0, 3'd0);

    // Mid-operation reset with two buffered loads and pending = 0x0C
    step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 3'd0, 3'd0);
    step(1'b1, 3'd0, 16'h5555, 1'b1, 3'd6, 16'h0606, 1'b0, 3'd0, 3'd0, 3'd0);
    step(1'b1, 3'd0, 16'h6666, 1'b1, 3'd7, 16'h0707, 1'b0, 3'd0, 3'd2, 3'd3);
    chk("prerst_pending", {24'd0, pending}, 32'h0C);
    chk("prerst_ready", {31'd0, mem_ready}, 32'h0);
    alu_valid = 1'b0; mem_valid = 1'b0; issue_en = 1'b0;
    ReadSelS = 3'd2; ReadSelT = 3'd3;
    #2;
    rst = 1'b0;
    #1;
    chkReset();
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle(3'd2, 3'd3);
      chk("postrst_idle", {31'd0, WrRegEn}, 32'h0);
    end

    // Randomised traffic
    for (int i = 0; i < 500; i++) begin
      logic av, mv, ie;
      av = ($urandom_range(0, 9) < 4);
      mv = ($urandom_range(0, 9) < 5);
      ie = ($urandom_range(0, 9) < 3);
      step(av, 3'($urandom), 16'($urandom), mv, 3'($urandom), 16'($urandom),
           ie, 3'($urandom), 3'($urandom), 3'($urandom));
    end
    for (int i = 0; i < 4; i++) idle(3'd0, 3'd0);
    chk("exp_drained", expQ.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
